// File: rtl/draw_point_arb_pkg.sv
// draw_point_arb_pkg: frame-buffer geometry, field widths and arbiter states
package draw_point_arb_pkg;
    localparam int COORD_W = 9;
    localparam int RGB_W = 12;
    localparam logic [COORD_W-1:0] RES_X = 9'd320;
    localparam logic [COORD_W-1:0] RES_Y = 9'd240;
    localparam logic [COORD_W-1:0] X_LAST = 9'd319;
    localparam logic [COORD_W-1:0] Y_LAST = 9'd239;
    typedef enum logic {ARB, CLEAR} arb_state_t;
endpackage

// File: rtl/draw_point_arbiter_rr_picker.sv
// rr_picker: round-robin pick, lowest requester above last wins, else lowest overall
module rr_picker #(
    parameter int N = 2,
    parameter int IW = 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last,
    output logic [N-1:0]  gnt,
    output logic          valid
);
    logic [N-1:0] hi, pool;
    always_comb begin
        hi = '0;
        for (int i = 0; i < N; i++) hi[i] = i > int'(last);
        pool = |(req & hi) ? (req & hi) : req;
        gnt = '0;
        for (int i = N - 1; i >= 0; i--)
            if (pool[i]) begin
                gnt = '0;
                gnt[i] = 1'b1;
            end
        valid = |req;
    end
endmodule

// File: rtl/draw_point_arbiter.sv
// draw_point_arbiter: round-robin draw-point arbiter toward a 320x240 frame buffer.
// The full-buffer clear sweep exists only when DRAW_POINT_ARB_CLEAR_EN is defined.
module draw_point_arbiter
    import draw_point_arb_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter logic [RGB_W-1:0] FILL_RGB12 = 12'h000
) (
    input  logic                       piul1Clock,
    input  logic                       piul1Reset,
    input  logic [NUM_REQ-1:0]         piul1Req,
    input  logic [NUM_REQ*COORD_W-1:0] piul9PosX,
    input  logic [NUM_REQ*COORD_W-1:0] piul9PosY,
    input  logic [NUM_REQ*RGB_W-1:0]   piul12Rgb,
    output logic [NUM_REQ-1:0]         poul1Gnt,
    input  logic                       piul1ClearStart,
    output logic                       poul1ClearBusy,
    output logic                       poul1ClearDone,
    output logic [COORD_W-1:0]         poul9PosX,
    output logic [COORD_W-1:0]         poul9PosY,
    output logic [RGB_W-1:0]           poul12Rgb,
    output logic                       poul1Update,
    output logic                       poul1RangeErr
);
    localparam int IW = (NUM_REQ > 2) ? 2 : 1;

    logic [IW-1:0] last_q, last_d, sel;
    logic [NUM_REQ-1:0] gnt_q, gnt_d, pick;
    logic pick_valid, arb_en, in_range, upd_q, upd_d, err_q, err_d;
    logic [COORD_W-1:0] x_q, x_d, y_q, y_d, req_x, req_y;
    logic [RGB_W-1:0] rgb_q, rgb_d, req_rgb;

    // a requester granted last cycle sits out this one
    rr_picker #(.N(NUM_REQ), .IW(IW)) u_pick (
        .req  (piul1Req & ~gnt_q),
        .last (last_q),
        .gnt  (pick),
        .valid(pick_valid)
    );

    always_comb begin
        sel = '0;
        req_x = '0;
        req_y = '0;
        req_rgb = '0;
        for (int i = 0; i < NUM_REQ; i++)
            if (pick[i]) begin
                sel = IW'(i);
                req_x = piul9PosX[i*COORD_W +: COORD_W];
                req_y = piul9PosY[i*COORD_W +: COORD_W];
                req_rgb = piul12Rgb[i*RGB_W +: RGB_W];
            end
        in_range = (req_x < RES_X) && (req_y < RES_Y);
    end

`ifdef DRAW_POINT_ARB_CLEAR_EN
    arb_state_t state_q, state_d;
    logic [COORD_W-1:0] cx_q, cx_d, cy_q, cy_d;
    logic done_q, done_d;
    assign arb_en = (state_q == ARB) && !piul1ClearStart;
    assign poul1ClearBusy = state_q == CLEAR;
    assign poul1ClearDone = done_q;
`else
    logic unused_clear;
    assign unused_clear = piul1ClearStart ^ (|FILL_RGB12);
    assign arb_en = 1'b1;
    assign poul1ClearBusy = 1'b0;
    assign poul1ClearDone = 1'b0;
`endif

    always_comb begin
        last_d = last_q;
        gnt_d = '0;
        upd_d = 1'b0;
        x_d = x_q;
        y_d = y_q;
        rgb_d = rgb_q;
        err_d = err_q;
`ifdef DRAW_POINT_ARB_CLEAR_EN
        state_d = state_q;
        cx_d = cx_q;
        cy_d = cy_q;
        done_d = 1'b0;
        if (state_q == CLEAR) begin
            upd_d = 1'b1;
            x_d = cx_q;
            y_d = cy_q;
            rgb_d = FILL_RGB12;
            cx_d = (cx_q == X_LAST) ? '0 : cx_q + COORD_W'(1);
            if (cx_q == X_LAST) cy_d = (cy_q == Y_LAST) ? '0 : cy_q + COORD_W'(1);
            if (cx_q == X_LAST && cy_q == Y_LAST) begin
                state_d = ARB;
                done_d = 1'b1;
            end
        end else if (piul1ClearStart) begin
            state_d = CLEAR;
        end
`endif
        if (arb_en && pick_valid) begin
            gnt_d = pick;
            last_d = sel;
            x_d = req_x;
            y_d = req_y;
            rgb_d = req_rgb;
            upd_d = in_range;
            err_d = err_q | ~in_range;
        end
    end

    always_ff @(posedge piul1Clock or posedge piul1Reset) begin
        if (piul1Reset) begin
            last_q <= '0;
            gnt_q <= '0;
            upd_q <= 1'b0;
            x_q <= '0;
            y_q <= '0;
            rgb_q <= '0;
            err_q <= 1'b0;
`ifdef DRAW_POINT_ARB_CLEAR_EN
            state_q <= ARB;
            cx_q <= '0;
            cy_q <= '0;
            done_q <= 1'b0;
`endif
        end else begin
            last_q <= last_d;
            gnt_q <= gnt_d;
            upd_q <= upd_d;
            x_q <= x_d;
            y_q <= y_d;
            rgb_q <= rgb_d;
            err_q <= err_d;
`ifdef DRAW_POINT_ARB_CLEAR_EN
            state_q <= state_d;
            cx_q <= cx_d;
            cy_q <= cy_d;
            done_q <= done_d;
`endif
        end
    end

    assign poul1Gnt = gnt_q;
    assign poul1Update = upd_q;
    assign poul9PosX = x_q;
    assign poul9PosY = y_q;
    assign poul12Rgb = rgb_q;
    assign poul1RangeErr = err_q;
endmodule

// File: tb/tb_draw_point_arbiter.sv
// tb_draw_point_arbiter: directed checks of arbitration, range errors, clear sweep and reset
module tb_draw_point_arbiter;
    logic clk = 1'b0, rst = 1'b1, cs = 1'b0;
    logic [1:0] req = '0;
    logic [17:0] px = {9'd30, 9'd10};
    logic [17:0] py = {9'd40, 9'd20};
    logic [23:0] prgb = {12'h123, 12'habc};
    logic [1:0] gnt;
    logic busy, done, upd, err;
    logic [8:0] ox, oy;
    logic [11:0] orgb;
    int tests = 0, fails = 0, cnt, bad, ex, ey;

    always #5 clk = ~clk;

    draw_point_arbiter #(.NUM_REQ(2), .FILL_RGB12(12'h000)) dut (
        .piul1Clock(clk), .piul1Reset(rst), .piul1Req(req),
        .piul9PosX(px), .piul9PosY(py), .piul12Rgb(prgb),
        .poul1Gnt(gnt), .piul1ClearStart(cs),
        .poul1ClearBusy(busy), .poul1ClearDone(done),
        .poul9PosX(ox), .poul9PosY(oy), .poul12Rgb(orgb),
        .poul1Update(upd), .poul1RangeErr(err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        @(negedge clk);
        chk("rst_gnt", gnt, 0);
        chk("rst_upd", upd, 0);
        chk("rst_xy", {ox, oy}, 0);
        chk("rst_err", err, 0);
        chk("rst_busy", busy, 0);
        rst = 1'b0;
        req = 2'b11;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("rr_gnt", gnt, (k % 2 == 0) ? 2'b10 : 2'b01);
            chk("rr_upd", upd, 1);
            chk("rr_x", ox, (k % 2 == 0) ? 30 : 10);
            chk("rr_rgb", orgb, (k % 2 == 0) ? 12'h123 : 12'habc);
        end
        req = 2'b00;
        @(negedge clk);
        chk("idle_gnt", gnt, 0);
        chk("idle_upd", upd, 0);
        chk("idle_hold_x", ox, 10);
        req = 2'b01;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("single_gnt", gnt, (k % 2 == 0) ? 2'b01 : 2'b00);
            chk("single_upd", upd, (k % 2 == 0) ? 1 : 0);
        end
        px[17:9] = 9'd320;
        py[17:9] = 9'd5;
        req = 2'b10;
        @(negedge clk);
        chk("oor_gnt", gnt, 2'b10);
        chk("oor_upd", upd, 0);
        chk("oor_err", err, 1);
        req = 2'b00;
        repeat (2) @(negedge clk);
        chk("err_sticky", err, 1);
        px[17:9] = 9'd0;
        py[17:9] = 9'd240;
        req = 2'b10;
        @(negedge clk);
        chk("y240_upd", upd, 0);
        req = 2'b00;
        px[17:9] = 9'd319;
        py[17:9] = 9'd239;
        @(negedge clk);
        req = 2'b10;
        @(negedge clk);
        chk("edge_upd", upd, 1);
        chk("edge_xy", {ox, oy}, {9'd319, 9'd239});
        #2 rst = 1'b1;
        #1;
        chk("arst_err", err, 0);
        chk("arst_xy", {ox, oy}, 0);
        chk("arst_upd", upd, 0);
        @(negedge clk);
        rst = 1'b0;
        px[17:9] = 9'd30;
        py[17:9] = 9'd40;
`ifdef DRAW_POINT_ARB_CLEAR_EN
        req = 2'b10;
        @(negedge clk);
        chk("pre_clr_gnt", gnt, 2'b10);
        req = 2'b11;
        cs = 1'b1;
        @(negedge clk);
        cs = 1'b0;
        chk("clr_start_busy", busy, 1);
        chk("clr_start_gnt", gnt, 0);
        chk("clr_start_upd", upd, 0);
        cnt = 1;
        bad = 0;
        ex = 0;
        ey = 0;
        while (busy && cnt < 80000) begin
            cs = (cnt == 500);
            @(negedge clk);
            if (busy) begin
                cnt++;
                if (gnt != 0 || !upd || ox != 9'(ex) || oy != 9'(ey) || orgb != 0) bad++;
                if (ex == 319) begin
                    ex = 0;
                    ey++;
                end else ex++;
            end
        end
        cs = 1'b0;
        chk("clr_cycles", cnt, 76800);
        chk("clr_seq_errs", bad, 0);
        chk("clr_done", done, 1);
        chk("clr_last_upd", upd, 1);
        chk("clr_last_xy", {ox, oy}, {9'd319, 9'd239});
        @(negedge clk);
        chk("post_clr_gnt", gnt, 2'b01);
        chk("post_clr_done", done, 0);
        chk("post_clr_x", ox, 10);
        req = 2'b00;
        cs = 1'b1;
        @(negedge clk);
        cs = 1'b0;
        repeat (1000) @(negedge clk);
        chk("mid_busy", busy, 1);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_upd", upd, 0);
        chk("mid_rst_xy", {ox, oy}, 0);
        chk("mid_rst_done", done, 0);
        @(negedge clk);
        rst = 1'b0;
        req = 2'b01;
        @(negedge clk);
        chk("after_rst_gnt", gnt, 2'b01);
        chk("after_rst_busy", busy, 0);
        chk("after_rst_upd", upd, 1);
`else
        req = 2'b11;
        cs = 1'b1;
        @(negedge clk);
        cs = 1'b0;
        chk("nc_busy", busy, 0);
        chk("nc_gnt", gnt, 2'b10);
        chk("nc_upd", upd, 1);
        @(negedge clk);
        chk("nc_gnt2", gnt, 2'b01);
        chk("nc_busy2", busy, 0);
        chk("nc_done", done, 0);
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
